// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage.
//   RESET_PC_DEFAULT : value the PC register holds after reset
//   BOOT_ADDR        : first fetch address (RESET_PC_DEFAULT + 4)
//   fetch_state_t    : fetch controller states
//   fetch_entry_t    : one instruction-buffer entry {inst, pc}
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1bfffffc;
    localparam logic [31:0] BOOT_ADDR        = RESET_PC_DEFAULT + 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Small circular FIFO of fetch entries, usable at any stage boundary.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : empties the FIFO; overrides push and pop in the same cycle
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : consume the head (ignored when empty)
//   head_valid  : FIFO not empty
//   head        : oldest entry; stable until popped
//   count       : number of stored entries
module inst_buffer
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic          head_valid,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop  && (cnt != '0);
    assign do_push = push && (cnt != CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign head_valid = (cnt != '0);
    assign head       = mem[rptr];
    assign count      = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the PC register (pc_write/npc), issues one
// instruction-memory request at a time at the current pc, and hands
// fetched words to decode through a 2-entry instruction buffer.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   pc                              : current PC from the PC register
//   pc_write, npc                   : PC register write enable / next value
//   br_valid, br_target             : one-cycle redirect from execute
//   imem_req, imem_addr, imem_gnt   : request handshake (addr = pc)
//   imem_rvalid, imem_rdata         : one-cycle response
//   inst_valid, inst, inst_pc       : buffer head towards decode
//   id_ready                        : decode consumes head this cycle
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_write,
    output logic [31:0] npc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_d;
    logic          kill;
    logic          kill_d;
    logic [31:0]   req_pc;
    logic [31:0]   req_pc_d;
    logic [CW-1:0] count;
    logic          req_raw;
    logic          pc_write_raw;
    logic          push;
    logic          flush;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign npc = br_valid ? br_target : pc + 32'd4;
    assign pop = inst_valid && id_ready;

    always_comb begin
        state_d      = state;
        kill_d       = kill;
        req_pc_d     = req_pc;
        req_raw      = 1'b0;
        pc_write_raw = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;

        case (state)
            S_BOOT: begin
                pc_write_raw = 1'b1;
                state_d      = S_REQ;
            end
            S_REQ: begin
                // Only ask when a slot is free so the response can always land.
                req_raw = (count < CW'(BUF_DEPTH));
                if (req_raw && imem_gnt) begin
                    req_pc_d = pc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push         = !kill;
                    pc_write_raw = !kill;
                    kill_d       = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Redirect wins over everything: flush, write the target, and make
        // sure the response of any in-flight (now stale) request is dropped.
        if (br_valid) begin
            pc_write_raw = 1'b1;
            flush        = 1'b1;
            push         = 1'b0;
            if (state == S_REQ && req_raw && imem_gnt) begin
                kill_d = 1'b1;
            end
            if (state == S_WAIT && !imem_rvalid) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_BOOT;
            kill   <= 1'b0;
            req_pc <= RESET_PC + 32'd4;
        end else begin
            state  <= state_d;
            kill   <= kill_d;
            req_pc <= req_pc_d;
        end
    end

    // Outputs are forced low while reset is held; S_BOOT would otherwise
    // show pc_write during reset.
    assign pc_write  = pc_write_raw && !rst;
    assign imem_req  = req_raw && !rst;
    assign imem_addr = rst ? '0 : pc;

    assign push_entry = '{inst: imem_rdata, pc: req_pc};

    inst_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (inst_valid),
        .head       (head),
        .count      (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1bfffffc;
    localparam logic [31:0] BOOT   = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_write;
    logic [31:0] npc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // environment knobs
    int unsigned gnt_pct  = 100;
    int unsigned spur_pct = 0;
    int unsigned lat_min  = 0;
    int unsigned lat_max  = 0;
    int unsigned br_mode  = 0;
    bit          mem_off  = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          rdy_val  = 1'b1;
    bit          br_req   = 1'b0;
    logic [31:0] br_tgt   = '0;

    // memory and reference-model state
    bit          pending  = 1'b0;
    logic [31:0] pend_addr;
    int unsigned delay    = 0;
    int          resp_cnt = 0;
    int          consumed = 0;
    logic [31:0] exp_pc   = BOOT;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_write    (pc_write),
        .npc         (npc),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    // The PC register this stage drives.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= RST_PC;
        else if (pc_write) pc <= npc;
    end

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == BOOT) ? 32'h02800000 : {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] off;
        off = $urandom_range(0, 1023);
        return BOOT + (off << 2);
    endfunction

    // One clock cycle: drive inputs after the falling edge, then check the
    // instruction stream seen by decode against the expected program order.
    task automatic tick();
        logic fire;
        @(negedge clk);
        id_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        if (!mem_off) begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending && delay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
                pending     = 1'b0;
                resp_cnt++;
            end else if (pending) begin
                delay--;
            end else if ($urandom_range(0, 99) < spur_pct) begin
                imem_rvalid = 1'b1;
            end
            imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
        case (br_mode)
            1:       fire = ($urandom_range(0, 99) < 4);
            2:       fire = imem_req && imem_gnt && ($urandom_range(0, 1) == 1);
            3:       fire = imem_rvalid && inst_valid && id_ready;
            default: fire = 1'b0;
        endcase
        br_valid  = br_req || fire;
        br_target = br_req ? br_tgt : rand_target();
        #1;
        if (rst) begin
            exp_pc  = BOOT;
            pending = 1'b0;
        end else begin
            n_checks++;
            if (npc !== (br_valid ? br_target : pc + 32'd4))
                $display("FAIL npc: got %h expected %h", npc, br_valid ? br_target : pc + 32'd4);
            else n_pass++;
            if (br_valid) begin
                n_checks++;
                if (pc_write !== 1'b1) $display("FAIL br_pc_write: got %b expected 1", pc_write);
                else n_pass++;
                exp_pc = br_target;
            end else if (inst_valid && id_ready) begin
                n_checks++;
                if (inst_pc !== exp_pc || inst !== memf(exp_pc))
                    $display("FAIL stream: got pc %h inst %h expected pc %h inst %h",
                             inst_pc, inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (imem_req && imem_gnt && !mem_off) begin
                n_checks++;
                if (imem_addr !== pc) $display("FAIL req_addr: got %h expected %h", imem_addr, pc);
                else n_pass++;
                pending   = 1'b1;
                pend_addr = imem_addr;
                delay     = $urandom_range(lat_min, lat_max);
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        br_req = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        resp_cnt = 0;
        pending  = 1'b0;
        exp_pc   = BOOT;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (pc_write !== 1'b0) $display("FAIL rst_pc_write: got %b expected 0", pc_write); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", imem_addr); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h expected 0", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); else n_pass++;
        n_checks++; if (npc !== BOOT) $display("FAIL rst_npc: got %h expected %h", npc, BOOT); else n_pass++;
    endtask

    task automatic test_boot();
        rdy_val = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 0; spur_pct = 0;
        rst = 1'b0;
        #1;
        n_checks++; if (pc_write !== 1'b1) $display("FAIL boot_pc_write: got %b expected 1", pc_write); else n_pass++;
        n_checks++; if (npc !== BOOT) $display("FAIL boot_npc: got %h expected %h", npc, BOOT); else n_pass++;
        tick();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL boot_req: got %b expected 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== BOOT) $display("FAIL boot_addr: got %h expected %h", imem_addr, BOOT); else n_pass++;
        tick();
        n_checks++; if (pc_write !== 1'b1) $display("FAIL boot_step_write: got %b expected 1", pc_write); else n_pass++;
        n_checks++; if (npc !== BOOT + 32'd4) $display("FAIL boot_step_npc: got %h expected %h", npc, BOOT + 32'd4); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL boot_valid: got %b expected 1", inst_valid); else n_pass++;
        n_checks++; if (inst_pc !== BOOT) $display("FAIL boot_inst_pc: got %h expected %h", inst_pc, BOOT); else n_pass++;
        n_checks++; if (inst !== 32'h02800000) $display("FAIL boot_inst: got %h expected 02800000", inst); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== BOOT + 32'd4)
            $display("FAIL boot_next_req: got req %b addr %h expected req 1 addr %h", imem_req, imem_addr, BOOT + 32'd4);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        rdy_val = 1'b0; gnt_pct = 100; lat_min = 0; lat_max = 0;
        do_reset();
        repeat (12) tick();
        n_checks++; if (resp_cnt != 2) $display("FAIL bp_resp_count: got %0d expected 2", resp_cnt); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_req_held: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (pc !== BOOT + 32'd8) $display("FAIL bp_pc: got %h expected %h", pc, BOOT + 32'd8); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== BOOT)
            $display("FAIL bp_head: got valid %b pc %h expected valid 1 pc %h", inst_valid, inst_pc, BOOT);
        else n_pass++;
        rdy_val = 1'b1;
        tick();
        rdy_val = 1'b0;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== BOOT + 32'd4)
            $display("FAIL bp_after_pop: got valid %b pc %h expected valid 1 pc %h", inst_valid, inst_pc, BOOT + 32'd4);
        else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== BOOT + 32'd8)
            $display("FAIL bp_req_resume: got req %b addr %h expected req 1 addr %h", imem_req, imem_addr, BOOT + 32'd8);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit found;
        int r0;
        rdy_val = 1'b0; gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (inst_valid && inst_pc == BOOT) found = 1'b1;
        end
        rdy_val = 1'b1;
        tick();
        rdy_val = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && imem_gnt && imem_addr == BOOT + 32'd8) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL rw_grant_timeout: got none expected grant at %h", BOOT + 32'd8); else n_pass++;
        br_req = 1'b1; br_tgt = 32'h1c000100;
        tick();
        br_req = 1'b0;
        r0 = resp_cnt;
        n_checks++; if (pc_write !== 1'b1 || npc !== 32'h1c000100)
            $display("FAIL rw_redirect: got write %b npc %h expected write 1 npc 1c000100", pc_write, npc);
        else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_flush: got %b expected 0", inst_valid); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 32'h1c000100)
            $display("FAIL rw_next_addr: got found %b addr %h expected 1c000100", found, imem_addr);
        else n_pass++;
        n_checks++; if (resp_cnt != r0 + 1) $display("FAIL rw_stale_resp: got %0d expected %0d", resp_cnt, r0 + 1); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_discard: got %b expected 0", inst_valid); else n_pass++;
        rdy_val = 1'b1; lat_min = 0; lat_max = 2;
        repeat (20) tick();
    endtask

    task automatic test_coincident();
        int c0;
        rdy_rand = 1'b1; gnt_pct = 70; lat_min = 0; lat_max = 2; spur_pct = 0;
        do_reset();
        c0 = consumed;
        br_mode = 2;
        repeat (300) tick();
        br_mode = 3;
        repeat (300) tick();
        br_mode = 0;
        repeat (20) tick();
        n_checks++; if (consumed - c0 < 20) $display("FAIL co_progress: got %0d expected >= 20", consumed - c0); else n_pass++;
    endtask

    task automatic test_random();
        int c0;
        rdy_rand = 1'b1; gnt_pct = 60; lat_min = 0; lat_max = 3; spur_pct = 10;
        c0 = consumed;
        br_mode = 1;
        repeat (1500) tick();
        br_mode = 0; spur_pct = 0;
        repeat (20) tick();
        n_checks++; if (consumed - c0 < 30) $display("FAIL rnd_progress: got %0d expected >= 30", consumed - c0); else n_pass++;
        rdy_rand = 1'b0;
    endtask

    task automatic test_reset_wait();
        bit found;
        rdy_val = 1'b1; gnt_pct = 100; lat_min = 4; lat_max = 4; spur_pct = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && imem_gnt) found = 1'b1;
        end
        tick();
        mem_off = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (pc_write !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL rw_rst_ctrl: got write %b req %b addr %h expected 0 0 0", pc_write, imem_req, imem_addr);
        else n_pass++;
        n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0)
            $display("FAIL rw_rst_buf: got valid %b inst %h pc %h expected 0 0 0", inst_valid, inst, inst_pc);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hdeadbeef;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== BOOT)
            $display("FAIL rw_restart: got req %b addr %h expected req 1 addr %h", imem_req, imem_addr, BOOT);
        else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_late_resp: got %b expected 0", inst_valid); else n_pass++;
        imem_rvalid = 1'b0; mem_off = 1'b0; pending = 1'b0; lat_min = 0; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (inst_valid) found = 1'b1;
        end
        n_checks++; if (!found || inst_pc !== BOOT || inst !== 32'h02800000)
            $display("FAIL rw_first_inst: got found %b pc %h inst %h expected pc %h inst 02800000", found, inst_pc, inst, BOOT);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit found;
        rdy_val = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 1;
        do_reset();
        repeat (4) tick();
        br_req = 1'b1; br_tgt = 32'hfffffff8;
        tick();
        br_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (pc == 32'hfffffffc && !br_valid) begin
                found = 1'b1;
                n_checks++; if (npc !== 32'h0) $display("FAIL wrap_npc: got %h expected 00000000", npc); else n_pass++;
            end
        end
        n_checks++; if (!found) $display("FAIL wrap_reach: got none expected pc fffffffc"); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (inst_valid && inst_pc == 32'h0) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL wrap_fetch0: got none expected inst_pc 00000000"); else n_pass++;
    endtask

    initial begin
        br_valid = 1'b0; br_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect_wait();
        test_coincident();
        test_random();
        test_reset_wait();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
